// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams instruction words into CPU instruction memory over a
// valid/ready handshake, then holds the CPU in reset for a guard interval before release.
module imem_boot_loader #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        overflow_err
);

  localparam int unsigned CNT_W  = $clog2(MAX_WORDS) + 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HOLD_W-1:0] hold_q;
  logic              init_q;
  logic [31:0]       data_q;
  logic [31:0]       addr_q;
  logic              cpu_rst_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [CNT_W-1:0]  cnt_d;
  logic [31:0]       addr_d;

  assign cnt_d  = cnt_q + CNT_W'(1);
  assign addr_d = 32'(cnt_q) * 32'(ADDR_STEP);

  // Controller state and all registered outputs; start is only honoured outside LOAD/HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      init_q    <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            state_q   <= S_LOAD;
            cnt_q     <= '0;
            init_q    <= 1'b1;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            data_q <= word_data;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            if (word_last) begin
              state_q <= S_HOLD;
              hold_q  <= '0;
            end else if (cnt_d == CNT_W'(MAX_WORDS)) begin
              state_q <= S_ERR;
              init_q  <= 1'b0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Last word is written at the closing edge of the first HOLD cycle.
          init_q <= 1'b0;
          if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
            state_q   <= S_RUN;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign word_ready                     = (state_q == S_LOAD);
  assign initialize                     = init_q;
  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;
  assign cpu_rst                        = cpu_rst_q;
  assign busy                           = busy_q;
  assign done                           = done_q;
  assign overflow_err                   = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: behavioural reference model compared every
// cycle, directed load scenarios with random gaps, then a randomized free-running phase.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst, start, word_valid, word_last;
  logic [31:0] word_data;
  logic        word_ready, initialize, cpu_rst, busy, done, overflow_err;
  logic [31:0] init_data, init_addr;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .word_valid                     (word_valid),
    .word_data                      (word_data),
    .word_last                      (word_last),
    .word_ready                     (word_ready),
    .initialize                     (initialize),
    .instruction_initialize_data    (init_data),
    .instruction_initialize_address (init_addr),
    .cpu_rst                        (cpu_rst),
    .busy                           (busy),
    .done                           (done),
    .overflow_err                   (overflow_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: operating mode name plus program bookkeeping.
  typedef enum int {M_IDLE, M_LOAD, M_HOLD, M_RUN, M_ERR} mode_e;
  mode_e       m_mode;
  int          m_words;
  int          m_hold;
  logic        m_init;
  logic [31:0] m_data, m_addr;
  logic        m_acc;
  bit          m_valid = 0;

  // Instruction memory as the CPU would see it, written from DUT outputs.
  logic [31:0] mem [16];
  logic [31:0] prog [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic v,
                            input logic [31:0] d, input logic l);
    m_acc = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_words = 0; m_hold = 0;
      m_init = 1'b0; m_data = 32'h0; m_addr = 32'h0;
      m_valid = 1;
      return;
    end
    if (m_mode == M_LOAD) begin
      if (v) begin
        m_acc   = 1'b1;
        m_data  = d;
        m_addr  = 32'(m_words * 4);
        m_words = m_words + 1;
        if (l) begin
          m_mode = M_HOLD; m_hold = 0;
        end else if (m_words == 16) begin
          m_mode = M_ERR; m_init = 1'b0;
        end
      end
    end else if (m_mode == M_HOLD) begin
      m_init = 1'b0;
      m_hold = m_hold + 1;
      if (m_hold == 4) m_mode = M_RUN;
    end else if (s) begin
      m_mode = M_LOAD; m_words = 0; m_init = 1'b1;
    end
  endtask

  task automatic check_all();
    if (!m_valid) return;
    chk("word_ready",   32'(word_ready),   32'(m_mode == M_LOAD));
    chk("initialize",   32'(initialize),   32'(m_init));
    chk("data",         init_data,         m_data);
    chk("address",      init_addr,         m_addr);
    chk("cpu_rst",      32'(cpu_rst),      32'(m_mode != M_RUN));
    chk("busy",         32'(busy),         32'(m_mode == M_LOAD || m_mode == M_HOLD));
    chk("done",         32'(done),         32'(m_mode == M_RUN));
    chk("overflow_err", 32'(overflow_err), 32'(m_mode == M_ERR));
  endtask

  // One clock: apply inputs, model and memory update at the edge, compare #1 later.
  task automatic cyc(input logic r, input logic s, input logic v,
                     input logic [31:0] d, input logic l);
    logic        w_en;
    logic [31:0] w_a, w_d;
    rst = r; start = s; word_valid = v; word_data = d; word_last = l;
    w_en = initialize; w_a = init_addr; w_d = init_data;
    @(posedge clk);
    if (w_en === 1'b1 && w_a < 32'd64) mem[w_a[5:2]] = w_d;
    model_step(r, s, v, d, l);
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
  endtask

  // Start pulse, then offer prog[] with random gaps; optionally mark the last word.
  task automatic load_prog(input int gapmax, input bit with_last);
    int n;
    cyc(1'b0, 1'b1, 1'b0, $urandom, 1'b0);
    foreach (prog[i]) begin
      repeat ($urandom_range(gapmax, 0)) cyc(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      n = 0;
      do begin
        cyc(1'b0, 1'b0, 1'b1, prog[i], with_last && (i == prog.size() - 1));
        n++;
      end while (!m_acc && n < 20);
      if (!m_acc) chk("accept_timeout", 32'(n), 32'd0);
    end
  endtask

  task automatic wait_run();
    int n = 0;
    while (done !== 1'b1 && n < 40) begin idle(); n++; end
    chk("reach_run", 32'(done), 32'd1);
  endtask

  task automatic check_mem(input string nm);
    foreach (prog[i]) chk(nm, mem[i], prog[i]);
  endtask

  initial begin
    int n;
    foreach (mem[i]) mem[i] = 32'h0;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1);
    chk("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reset_addr", init_addr, 32'h0);

    // Word offered with start is not accepted; then back-to-back three-word program.
    cyc(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("start_no_accept", 32'(m_acc), 32'd0);
    chk("start_load_ready", 32'(word_ready), 32'd1);
    prog = '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820};
    foreach (prog[i]) cyc(1'b0, 1'b0, 1'b1, prog[i], i == 2);
    chk("t1_last_addr", init_addr, 32'd8);
    chk("t1_last_data", init_data, 32'h0022_1820);
    chk("t1_init_hold1", 32'(initialize), 32'd1);
    idle();
    chk("t1_init_fall", 32'(initialize), 32'd0);
    n = 1;
    while (cpu_rst === 1'b1 && n < 20) begin idle(); n++; end
    chk("t1_hold_cycles", 32'(n), 32'd4);
    chk("t1_done", 32'(done), 32'd1);
    check_mem("t1_mem");

    // Same program with valid gaps, restarted from RUN.
    foreach (mem[i]) mem[i] = 32'h0;
    load_prog(3, 1'b1);
    wait_run();
    check_mem("t2_mem");

    // 16 words without last -> overflow, then restart at address 0.
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back($urandom);
    load_prog(1, 1'b0);
    chk("t3_err", 32'(overflow_err), 32'd1);
    chk("t3_ready", 32'(word_ready), 32'd0);
    chk("t3_init", 32'(initialize), 32'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
    chk("t3_err_sticky", 32'(overflow_err), 32'd1);
    prog = '{32'hA5A5_0001, 32'hA5A5_0002};
    load_prog(2, 1'b1);
    chk("t3_restart_addr", init_addr, 32'd4);
    wait_run();
    check_mem("t3_mem");

    // Reset after second accept.
    prog = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    prog.pop_back();
    load_prog(2, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h5555_5555, 1'b0);
    chk("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t4_init", 32'(initialize), 32'd0);
    chk("t4_addr", init_addr, 32'd0);

    // Reload from RUN with a single 0xFFFFFFFF word.
    prog = '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820};
    load_prog(0, 1'b1);
    wait_run();
    prog = '{32'hFFFF_FFFF};
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("t5_addr", init_addr, 32'd0);
    wait_run();
    check_mem("t5_mem");
    chk("t5_untouched", mem[1], 32'h2002_0003);

    // Randomized free run against the model.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(63, 0) == 0, $urandom_range(15, 0) == 0,
          $urandom_range(1, 0) == 1, $urandom, $urandom_range(7, 0) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
